// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: ROB sizing and entry type codes shared by the ROB, its interface and consumers.
package reorder_buffer_pkg;
   localparam int ROB_SIZE_BIT = 3;
   localparam int DEPTH = 2 ** ROB_SIZE_BIT;
   localparam logic [ROB_SIZE_BIT:0] FULL_CNT = DEPTH[ROB_SIZE_BIT:0];
   typedef enum logic [1:0] {ROB_REG = 2'd0, ROB_BR = 2'd1, ROB_ST = 2'd2} rob_type_e;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, writeback, operand query and commit signals of the reorder buffer.
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;
   logic                    issue_valid;
   rob_type_e               issue_type;
   logic [4:0]              issue_rd;
   logic                    issue_pred_taken;
   logic [31:0]             issue_fallthru;
   logic [ROB_SIZE_BIT-1:0] tail_idx;
   logic                    rob_full;
   logic                    wb_valid;
   logic [ROB_SIZE_BIT-1:0] wb_idx;
   logic [31:0]             wb_val;
   logic                    wb_taken;
   logic [31:0]             wb_target;
   logic [ROB_SIZE_BIT-1:0] qry_idx1, qry_idx2;
   logic                    qry_ready1, qry_ready2;
   logic [31:0]             qry_val1, qry_val2;
   logic [4:0]              rob_set_idx;
   logic [31:0]             rob_set_reg_val;
   logic [ROB_SIZE_BIT-1:0] rob_set_recorder;
   logic                    rob_clear;
   logic [31:0]             clear_pc;
   logic                    st_commit;
   logic [ROB_SIZE_BIT-1:0] st_commit_idx;
   modport master (
      output issue_valid, issue_type, issue_rd, issue_pred_taken, issue_fallthru,
      output wb_valid, wb_idx, wb_val, wb_taken, wb_target, qry_idx1, qry_idx2,
      input  tail_idx, rob_full, qry_ready1, qry_ready2, qry_val1, qry_val2,
      input  rob_set_idx, rob_set_reg_val, rob_set_recorder, rob_clear, clear_pc,
      input  st_commit, st_commit_idx
   );
   modport slave (
      input  issue_valid, issue_type, issue_rd, issue_pred_taken, issue_fallthru,
      input  wb_valid, wb_idx, wb_val, wb_taken, wb_target, qry_idx1, qry_idx2,
      output tail_idx, rob_full, qry_ready1, qry_ready2, qry_val1, qry_val2,
      output rob_set_idx, rob_set_reg_val, rob_set_recorder, rob_clear, clear_pc,
      output st_commit, st_commit_idx
   );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular buffer retiring results in program order, one per cycle, flushing on mispredict.
// Define ROB_FORWARD_EN to enable same-cycle operand forwarding on the query ports.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input logic             clk_in,
   input logic             rst_in,
   input logic             rdy_in,
   reorder_buffer_if.slave rob
);
   logic [DEPTH-1:0]        busy, ready, pred_taken, taken;
   rob_type_e               typ      [DEPTH];
   logic [4:0]              rd       [DEPTH];
   logic [31:0]             val      [DEPTH];
   logic [31:0]             target   [DEPTH];
   logic [31:0]             fallthru [DEPTH];
   logic [ROB_SIZE_BIT-1:0] head, tail;
   logic [ROB_SIZE_BIT:0]   count, count_n;
   logic                    issue_ok, wb_ok, head_wb, commit, mispredict, head_taken;
   logic [31:0]             head_val, head_target;

   assign issue_ok = rdy_in && rob.issue_valid && !rob.rob_full;
   assign wb_ok = rdy_in && rob.wb_valid && busy[rob.wb_idx];
   // A writeback to the head commits at the same edge, so bypass its fields.
   assign head_wb = wb_ok && rob.wb_idx == head;
   assign head_val = head_wb ? rob.wb_val : val[head];
   assign head_taken = head_wb ? rob.wb_taken : taken[head];
   assign head_target = head_wb ? rob.wb_target : target[head];
   assign commit = rdy_in && busy[head] && (ready[head] || head_wb) && !rob.rob_clear;
   assign mispredict = commit && typ[head] == ROB_BR && head_taken != pred_taken[head];
   assign count_n = count + (ROB_SIZE_BIT+1)'(issue_ok) - (ROB_SIZE_BIT+1)'(commit);
   assign rob.tail_idx = tail;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         busy <= '0;
         ready <= '0;
         head <= '0;
         tail <= '0;
         count <= '0;
         rob.rob_full <= 1'b0;
         rob.rob_set_idx <= '0;
         rob.rob_set_reg_val <= '0;
         rob.rob_set_recorder <= '0;
         rob.rob_clear <= 1'b0;
         rob.clear_pc <= '0;
         rob.st_commit <= 1'b0;
         rob.st_commit_idx <= '0;
      end else if (!rdy_in) begin
         rob.rob_set_idx <= '0;
         rob.rob_clear <= 1'b0;
         rob.st_commit <= 1'b0;
      end else begin
         rob.rob_set_idx <= '0;
         rob.st_commit <= 1'b0;
         rob.rob_clear <= mispredict;
         if (mispredict) begin
            busy <= '0;
            ready <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            rob.rob_full <= 1'b0;
            rob.clear_pc <= head_taken ? head_target : fallthru[head];
         end else begin
            if (issue_ok) begin
               busy[tail] <= 1'b1;
               ready[tail] <= 1'b0;
               tail <= tail + 1'b1;
            end
            if (wb_ok) ready[rob.wb_idx] <= 1'b1;
            if (commit) begin
               busy[head] <= 1'b0;
               head <= head + 1'b1;
               if (typ[head] == ROB_REG) begin
                  rob.rob_set_idx <= rd[head];
                  rob.rob_set_reg_val <= head_val;
                  rob.rob_set_recorder <= head;
               end
               if (typ[head] == ROB_ST) begin
                  rob.st_commit <= 1'b1;
                  rob.st_commit_idx <= head;
               end
            end
            count <= count_n;
            rob.rob_full <= count_n == FULL_CNT;
         end
      end
   end

   // Payload storage needs no reset: busy gates every use of it.
   always_ff @(posedge clk_in) begin
      if (issue_ok) begin
         typ[tail] <= rob.issue_type;
         rd[tail] <= rob.issue_type == ROB_REG ? rob.issue_rd : 5'd0;
         pred_taken[tail] <= rob.issue_pred_taken;
         fallthru[tail] <= rob.issue_fallthru;
      end
      if (wb_ok) begin
         val[rob.wb_idx] <= rob.wb_val;
         taken[rob.wb_idx] <= rob.wb_taken;
         target[rob.wb_idx] <= rob.wb_target;
      end
   end

`ifdef ROB_FORWARD_EN
   assign rob.qry_ready1 = busy[rob.qry_idx1] && (ready[rob.qry_idx1] || (wb_ok && rob.wb_idx == rob.qry_idx1));
   assign rob.qry_ready2 = busy[rob.qry_idx2] && (ready[rob.qry_idx2] || (wb_ok && rob.wb_idx == rob.qry_idx2));
   assign rob.qry_val1 = wb_ok && rob.wb_idx == rob.qry_idx1 ? rob.wb_val : val[rob.qry_idx1];
   assign rob.qry_val2 = wb_ok && rob.wb_idx == rob.qry_idx2 ? rob.wb_val : val[rob.qry_idx2];
`else
   assign rob.qry_ready1 = 1'b0;
   assign rob.qry_ready2 = 1'b0;
   assign rob.qry_val1 = '0;
   assign rob.qry_val2 = '0;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed checks of issue, in-order commit, full, flush, store and forwarding.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;
   logic clk_in = 1'b0;
   logic rst_in, rdy_in;
   int n_cmp = 0;
   int n_bad = 0;
   reorder_buffer_if rob();
   reorder_buffer dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob(rob));
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset;
      rob.issue_valid = 1'b0;
      rob.wb_valid = 1'b0;
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
   endtask

   task automatic issue(input rob_type_e t, input logic [4:0] rd, input logic p, input logic [31:0] ft);
      rob.issue_valid = 1'b1;
      rob.issue_type = t;
      rob.issue_rd = rd;
      rob.issue_pred_taken = p;
      rob.issue_fallthru = ft;
      tick();
      rob.issue_valid = 1'b0;
   endtask

   task automatic wb(input logic [2:0] idx, input logic [31:0] v, input logic tk, input logic [31:0] tg);
      rob.wb_valid = 1'b1;
      rob.wb_idx = idx;
      rob.wb_val = v;
      rob.wb_taken = tk;
      rob.wb_target = tg;
      tick();
      rob.wb_valid = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] rd, input logic [31:0] v, input logic [2:0] rec);
      chk({tag, "_rd"}, 32'(rob.rob_set_idx), 32'(rd));
      chk({tag, "_val"}, rob.rob_set_reg_val, v);
      chk({tag, "_rec"}, 32'(rob.rob_set_recorder), 32'(rec));
   endtask

   initial begin
      rdy_in = 1'b1;
      rob.issue_type = ROB_REG;
      rob.issue_rd = '0;
      rob.issue_pred_taken = 1'b0;
      rob.issue_fallthru = '0;
      rob.wb_idx = '0;
      rob.wb_val = '0;
      rob.wb_taken = 1'b0;
      rob.wb_target = '0;
      rob.qry_idx1 = '0;
      rob.qry_idx2 = '0;
      do_reset();
      chk("rst_set_idx", 32'(rob.rob_set_idx), 0);
      chk("rst_full", 32'(rob.rob_full), 0);
      chk("rst_tail", 32'(rob.tail_idx), 0);
      chk("rst_clear", 32'(rob.rob_clear), 0);
      chk("rst_st", 32'(rob.st_commit), 0);
      // single REG entry round trip
      issue(ROB_REG, 5'd5, 1'b0, 32'h0);
      chk("t1_tail", 32'(rob.tail_idx), 1);
      wb(3'd0, 32'h1234, 1'b0, 32'h0);
      chk_reg("t1", 5'd5, 32'h1234, 3'd0);
      tick();
      chk("t1_pulse", 32'(rob.rob_set_idx), 0);
      // out-of-order writeback, in-order commit
      do_reset();
      issue(ROB_REG, 5'd1, 1'b0, 32'h0);
      issue(ROB_REG, 5'd2, 1'b0, 32'h0);
      issue(ROB_REG, 5'd3, 1'b0, 32'h0);
      wb(3'd2, 32'h22, 1'b0, 32'h0);
      chk("t2_hold2", 32'(rob.rob_set_idx), 0);
      wb(3'd1, 32'h11, 1'b0, 32'h0);
      chk("t2_hold1", 32'(rob.rob_set_idx), 0);
      wb(3'd0, 32'h10, 1'b0, 32'h0);
      chk_reg("t2_c0", 5'd1, 32'h10, 3'd0);
      tick();
      chk_reg("t2_c1", 5'd2, 32'h11, 3'd1);
      tick();
      chk_reg("t2_c2", 5'd3, 32'h22, 3'd2);
      tick();
      chk("t2_done", 32'(rob.rob_set_idx), 0);
      // fill to depth, drop issues while full
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("t3_notfull7", 32'(rob.rob_full), 0);
         issue(ROB_REG, 5'(i + 1), 1'b0, 32'h0);
      end
      chk("t3_full", 32'(rob.rob_full), 1);
      chk("t3_tailwrap", 32'(rob.tail_idx), 0);
      issue(ROB_REG, 5'd20, 1'b0, 32'h0);
      chk("t3_drop_tail", 32'(rob.tail_idx), 0);
      chk("t3_drop_full", 32'(rob.rob_full), 1);
      rob.issue_valid = 1'b1;
      rob.issue_rd = 5'd21;
      wb(3'd0, 32'hAA, 1'b0, 32'h0);
      rob.issue_valid = 1'b0;
      chk_reg("t3_c0", 5'd1, 32'hAA, 3'd0);
      chk("t3_freed", 32'(rob.rob_full), 0);
      chk("t3_drop2_tail", 32'(rob.tail_idx), 0);
      issue(ROB_REG, 5'd22, 1'b0, 32'h0);
      chk("t3_refill_tail", 32'(rob.tail_idx), 1);
      chk("t3_refull", 32'(rob.rob_full), 1);
      #2 rst_in = 1'b1;
      #1 chk("t3_async_tail", 32'(rob.tail_idx), 0);
      chk("t3_async_full", 32'(rob.rob_full), 0);
      tick();
      rst_in = 1'b0;
      // correct branch, then mispredicted branch with younger entries
      issue(ROB_BR, 5'd0, 1'b1, 32'h8);
      wb(3'd0, 32'h0, 1'b1, 32'h80);
      chk("t4_ok_clear", 32'(rob.rob_clear), 0);
      chk("t4_ok_rd", 32'(rob.rob_set_idx), 0);
      issue(ROB_BR, 5'd9, 1'b0, 32'h44);
      issue(ROB_REG, 5'd7, 1'b0, 32'h0);
      issue(ROB_REG, 5'd8, 1'b0, 32'h0);
      wb(3'd2, 32'h1, 1'b0, 32'h0);
      wb(3'd1, 32'h0, 1'b1, 32'h100);
      chk("t4_clear", 32'(rob.rob_clear), 1);
      chk("t4_pc", rob.clear_pc, 32'h100);
      chk("t4_norf", 32'(rob.rob_set_idx), 0);
      chk("t4_tail", 32'(rob.tail_idx), 0);
      tick();
      chk("t4_clear_pulse", 32'(rob.rob_clear), 0);
      chk("t4_no_young", 32'(rob.rob_set_idx), 0);
      for (int i = 0; i < 7; i++) issue(ROB_REG, 5'd1, 1'b0, 32'h0);
      chk("t4_count0", 32'(rob.rob_full), 0);
      // store at index 3
      do_reset();
      for (int i = 0; i < 3; i++) issue(ROB_REG, 5'(i + 1), 1'b0, 32'h0);
      issue(ROB_ST, 5'd9, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) wb(3'(i), 32'(i), 1'b0, 32'h0);
      chk_reg("t5_pre", 5'd3, 32'h2, 3'd2);
      wb(3'd3, 32'h0, 1'b0, 32'h0);
      chk("t5_st", 32'(rob.st_commit), 1);
      chk("t5_st_idx", 32'(rob.st_commit_idx), 3);
      chk("t5_st_rd", 32'(rob.rob_set_idx), 0);
      tick();
      chk("t5_st_pulse", 32'(rob.st_commit), 0);
      // forwarding and stall
      do_reset();
      for (int i = 0; i < 3; i++) issue(ROB_REG, 5'(i + 4), 1'b0, 32'h0);
      rob.wb_valid = 1'b1;
      rob.wb_idx = 3'd2;
      rob.wb_val = 32'd7;
      rob.qry_idx1 = 3'd2;
      rob.qry_idx2 = 3'd0;
      #1;
`ifdef ROB_FORWARD_EN
      chk("t6_fwd_rdy", 32'(rob.qry_ready1), 1);
      chk("t6_fwd_val", rob.qry_val1, 32'd7);
`else
      chk("t6_fwd_rdy", 32'(rob.qry_ready1), 0);
      chk("t6_fwd_val", rob.qry_val1, 32'd0);
`endif
      chk("t6_notready", 32'(rob.qry_ready2), 0);
      tick();
      rob.wb_valid = 1'b0;
      rob.qry_idx2 = 3'd2;
      #1;
`ifdef ROB_FORWARD_EN
      chk("t6_stored_rdy", 32'(rob.qry_ready2), 1);
      chk("t6_stored_val", rob.qry_val2, 32'd7);
`else
      chk("t6_stored_rdy", 32'(rob.qry_ready2), 0);
`endif
      rdy_in = 1'b0;
      wb(3'd0, 32'h55, 1'b0, 32'h0);
      chk("t6_stall", 32'(rob.rob_set_idx), 0);
      rdy_in = 1'b1;
      tick();
      chk("t6_stall_wb_lost", 32'(rob.rob_set_idx), 0);
      wb(3'd0, 32'h66, 1'b0, 32'h0);
      chk_reg("t6_c0", 5'd4, 32'h66, 3'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
